famicom_pad_reader: RTL and testbench

Host-side initiator for the Famicom/NES serial game-controller protocol, the counterpart of the pad-emulating shift register that answers the Gigatron's `famicom_latch`/`famicom_pulse`. The reader generates latch and pulse and samples the pad's serial data line. It then publishes the eight buttons as an active-high parallel word. It sits between a physical controller port and any consumer of a parallel button word, such as the joystick path that feeds the Gigatron shell.

---
 rtl/famicom_pad_reader_if.sv | 25 ++
 rtl/famicom_pad_reader.sv | 153 +++++++++++++++
 tb/tb_famicom_pad_reader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/famicom_pad_reader_if.sv
// Host-side bundle of the Famicom pad reader.
//   enable   : consumer -> reader, allow periodic auto-polling
//   poll_now : consumer -> reader, one-cycle request for an immediate frame
//   buttons  : reader -> consumer, active-high button word (bit k = k-th serial bit)
//   valid    : reader -> consumer, one-cycle strobe when buttons updates
//   busy     : reader -> consumer, frame in flight
interface famicom_pad_reader_if;
  logic       enable;
  logic       poll_now;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  // consumer side
  modport master (
    output enable, poll_now,
    input  buttons, valid, busy
  );

  // reader side
  modport slave (
    input  enable, poll_now,
    output buttons, valid, busy
  );
endinterface

// File: rtl/famicom_pad_reader.sv
// Famicom/NES controller reader: drives latch/pulse to the pad, samples the
// serial data line and publishes an active-high 8-bit button word.
//   clk_sys       : sole clock, rising edge
//   reset_n       : asynchronous active-low reset
//   famicom_data  : pad serial data (async, low = pressed)
//   famicom_latch : parallel-load strobe to the pad, idles low
//   famicom_pulse : shift clock to the pad, idles low
//   host          : enable / poll_now in, buttons / valid / busy out
module famicom_pad_reader #(
  parameter int LATCH_CYCLES = 4,
  parameter int PULSE_CYCLES = 4,
  parameter int POLL_CYCLES  = 1666667
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic famicom_data,
  output logic famicom_latch,
  output logic famicom_pulse,
  famicom_pad_reader_if.slave host
);

  localparam int PH_MAX = (LATCH_CYCLES > PULSE_CYCLES) ? LATCH_CYCLES : PULSE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int POLL_W = $clog2(POLL_CYCLES + 1);

  localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0]   PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LATCH, SETTLE, PULSE_HI, PULSE_LO, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [2:0]        bit_q,   bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        buttons_q, buttons_d;
  logic [POLL_W-1:0] poll_q,  poll_d;
  logic [1:0]        sync_q;
  logic              latch_q, pulse_q, busy_q, valid_q;
  logic              sample;
  logic              expire;

  assign expire = host.enable && (poll_q == POLL_LAST);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    sample    = 1'b0;

    // Free-running only while enabled; wraps on expiry even when the
    // expiry is ignored because a frame is still in flight.
    if (!host.enable || expire) poll_d = '0;
    else                        poll_d = poll_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (host.poll_now || expire) begin
          state_d = LATCH;
          phase_d = '0;
          bit_d   = '0;
          shift_d = '0;
          poll_d  = '0;
        end
      end
      LATCH: begin
        if (phase_q == LATCH_LAST) begin
          phase_d = '0;
          state_d = SETTLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SETTLE: begin
        if (phase_q == PULSE_LAST) begin
          phase_d = '0;
          sample  = 1'b1;
          state_d = PULSE_HI;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      PULSE_HI: begin
        if (phase_q == PULSE_LAST) begin
          phase_d = '0;
          state_d = PULSE_LO;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      PULSE_LO: begin
        if (phase_q == PULSE_LAST) begin
          phase_d = '0;
          sample  = 1'b1;
          state_d = (bit_q == 3'd7) ? DONE : PULSE_HI;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (sample) begin
      shift_d[bit_q] = ~sync_q[1];
      bit_d          = bit_q + 1'b1;
    end

    // Publish on entry to DONE so the last sampled bit is included.
    if (state_d == DONE) buttons_d = shift_d;
  end

  // Outputs are registered from the next state, so they line up exactly
  // with the state that owns them and never glitch.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      poll_q    <= '0;
      sync_q    <= 2'b11;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      poll_q    <= poll_d;
      sync_q    <= {sync_q[0], famicom_data};
      latch_q   <= (state_d == LATCH);
      pulse_q   <= (state_d == PULSE_HI);
      busy_q    <= (state_d != IDLE);
      valid_q   <= (state_d == DONE);
    end
  end

  assign famicom_latch = latch_q;
  assign famicom_pulse = pulse_q;
  assign host.buttons  = buttons_q;
  assign host.valid    = valid_q;
  assign host.busy     = busy_q;

endmodule

// File: tb/tb_famicom_pad_reader.sv
// Scoreboard bench for famicom_pad_reader: stimulus pushes expected
// {buttons, valid cycle} entries, a negedge monitor pops them on valid.
module tb_famicom_pad_reader;

  logic clk_sys = 1'b0;
  logic reset_n;
  logic famicom_data;
  logic famicom_latch, famicom_pulse;

  famicom_pad_reader_if pif ();

  famicom_pad_reader #(
    .LATCH_CYCLES(4), .PULSE_CYCLES(4), .POLL_CYCLES(200)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .famicom_data  (famicom_data),
    .famicom_latch (famicom_latch),
    .famicom_pulse (famicom_pulse),
    .host          (pif)
  );

  always #5 clk_sys = ~clk_sys;

  int tick = 0;
  always @(posedge clk_sys) tick <= tick + 1;

  // Pad model: loads on latch, shifts on pulse rising edge, idles high.
  logic [7:0] pad_bits = 8'hFF;
  logic [7:0] pad_sh   = 8'hFF;
  logic       pulse_d  = 1'b0;
  logic       use_pad  = 1'b1;
  logic       drv_data = 1'b1;
  always @(posedge clk_sys) begin
    pulse_d <= famicom_pulse;
    if (famicom_latch)               pad_sh <= pad_bits;
    else if (famicom_pulse && !pulse_d) pad_sh <= {1'b1, pad_sh[7:1]};
  end
  assign famicom_data = use_pad ? pad_sh[0] : drv_data;

  typedef struct { logic [7:0] btn; int cyc; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_sys) begin
    if (reset_n === 1'b1 && pif.valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid: buttons=%0h at tick %0d", pif.buttons, tick);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (pif.buttons !== e.btn || tick != e.cyc) begin
          n_bad++;
          $display("FAIL valid_word: got %0h at tick %0d want %0h at tick %0d",
                   pif.buttons, tick, e.btn, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic run_to(input int n);
    while (tick < n) step();
  endtask

  int t0;

  // Raise poll_now for the current cycle; t0 is that cycle, DUT starts next edge.
  task automatic start_frame(input bit expect_done, input logic [7:0] exp_btn);
    t0 = tick;
    pif.poll_now = 1'b1;
    if (expect_done) sb.push_back('{exp_btn, t0 + 65});
    step();
    pif.poll_now = 1'b0;
  endtask

  initial begin
    int rises;
    int a;
    logic [7:0] w;
    reset_n      = 1'b0;
    pif.enable   = 1'b0;
    pif.poll_now = 1'b0;
    #2;
    chk("rst_latch",   famicom_latch, 0);
    chk("rst_pulse",   famicom_pulse, 0);
    chk("rst_buttons", pif.buttons,   8'h00);
    chk("rst_valid",   pif.valid,     0);
    chk("rst_busy",    pif.busy,      0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();

    // Frame 1: all released, check exact latch/pulse/busy/valid timing.
    pad_bits = 8'hFF;
    start_frame(1, 8'h00);
    rises = 0;
    for (int c = 1; c <= 67; c++) begin
      if (c > 1) step();
      chk("f1_latch", famicom_latch, (c >= 1 && c <= 4));
      chk("f1_pulse", famicom_pulse, (c >= 9 && c <= 64 && ((c - 9) % 8) < 4));
      chk("f1_busy",  pif.busy,      (c >= 1 && c <= 65));
      chk("f1_valid", pif.valid,     (c == 65));
      if (famicom_pulse && !pulse_d) rises++;
    end
    chk("f1_pulse_count", rises, 7);

    // Frame 2: pattern, first serial bit lands in buttons[0].
    pad_bits = 8'b1010_0110;
    start_frame(1, 8'h59);
    run_to(t0 + 70);
    chk("f2_buttons", pif.buttons, 8'h59);

    // Ignored requests at cycles 10 and 65, accepted at 66.
    pad_bits = 8'b1111_0000;
    start_frame(1, 8'h0F);
    a = t0;
    run_to(a + 10);
    pif.poll_now = 1'b1; step(); pif.poll_now = 1'b0;
    run_to(a + 65);
    pif.poll_now = 1'b1; step(); pif.poll_now = 1'b0;
    chk("ign_busy_66", pif.busy, 0);
    pad_bits = 8'b0000_0001;
    pif.poll_now = 1'b1;
    sb.push_back('{8'hFE, a + 66 + 65});
    step();
    pif.poll_now = 1'b0;
    chk("ign_busy_67", pif.busy, 1);
    run_to(a + 140);
    chk("ign_busy_end", pif.busy, 0);

    // Data skew: change 3 cycles before each sample edge -> captured.
    use_pad  = 1'b0;
    drv_data = 1'b1;
    w = 8'b0110_1001;
    start_frame(1, 8'h96);
    a = t0;
    for (int k = 0; k < 8; k++) begin
      run_to(a + 6 + 8 * k);
      drv_data = w[k];
    end
    run_to(a + 70);
    chk("skew3_buttons", pif.buttons, 8'h96);

    // 1 cycle before -> previous value captured (bit0 sees the idle 1).
    drv_data = 1'b1;
    step();
    w = 8'h0F;
    start_frame(1, 8'hE0);
    a = t0;
    for (int k = 0; k < 8; k++) begin
      run_to(a + 8 + 8 * k);
      drv_data = w[k];
    end
    run_to(a + 70);
    chk("skew1_buttons", pif.buttons, 8'hE0);
    use_pad = 1'b1;

    // Auto-poll every 200 cycles; drop enable mid third frame.
    pad_bits = 8'h3C;
    a = tick;
    pif.enable = 1'b1;
    sb.push_back('{8'hC3, a + 264});
    sb.push_back('{8'hC3, a + 464});
    sb.push_back('{8'hC3, a + 664});
    run_to(a + 620);
    chk("auto_busy_mid", pif.busy, 1);
    pif.enable = 1'b0;
    run_to(a + 1100);
    chk("auto_busy_after", pif.busy, 0);
    chk("auto_buttons", pif.buttons, 8'hC3);

    // Reset mid-frame: outputs clear before the next edge.
    pad_bits = 8'h00;
    start_frame(0, 8'h00);
    run_to(t0 + 30);
    reset_n = 1'b0;
    #1;
    chk("mrst_latch",   famicom_latch, 0);
    chk("mrst_pulse",   famicom_pulse, 0);
    chk("mrst_busy",    pif.busy,      0);
    chk("mrst_valid",   pif.valid,     0);
    chk("mrst_buttons", pif.buttons,   8'h00);
    repeat (2) step();
    reset_n = 1'b1;
    a = tick;
    run_to(a + 150);
    chk("post_rst_busy",    pif.busy,      0);
    chk("post_rst_latch",   famicom_latch, 0);
    chk("post_rst_buttons", pif.buttons,   8'h00);

    // Idle still answers a fresh request.
    pad_bits = 8'b0111_1110;
    start_frame(1, 8'h81);
    run_to(t0 + 70);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing_valid: expected %0h at tick %0d never arrived", e.btn, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
